// File: rtl/memory_bus_pkg.sv
// Shared types and constants for the data-memory responder.
package memory_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_e;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    localparam int unsigned MAX_WAIT_STATES = 15;

endpackage

// File: rtl/memory_byte_lane_ram.sv
// 2^DEPTH_W x 16 storage, one write enable per byte lane, registered read.
module memory_byte_lane_ram #(
    parameter int unsigned DEPTH_W = 10
) (
    input  logic               clk_i,
    input  logic [DEPTH_W-1:0] addr_i,
    input  logic               we_lo_i,
    input  logic               we_hi_i,
    input  logic [15:0]        wdata_i,
    output logic [15:0]        rdata_o
);

    logic [7:0]  lo_mem [2**DEPTH_W];
    logic [7:0]  hi_mem [2**DEPTH_W];
    logic [15:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_lo_i) lo_mem[addr_i] <= wdata_i[7:0];
        if (we_hi_i) hi_mem[addr_i] <= wdata_i[15:8];
        rdata_q <= {hi_mem[addr_i], lo_mem[addr_i]};
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_bus_responder.sv
// Target end of the CPU memory path: wait states, byte/word access, one-cycle ack.
// Optional macro MEM_BYTE_SIGN_EXTEND_EN: byte reads sign-extend instead of zero-extend.
module memory_bus_responder
    import memory_bus_pkg::*;
#(
    parameter int unsigned WORD        = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH_W     = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic              byte_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD-1:0]   wdata_i,
    output logic              ack_o,
    output logic              err_o,
    output logic [WORD-1:0]   rdata_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] WAIT_INIT =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic                 byte_q, byte_d;
    logic                 lane_q, lane_d;
    logic [DEPTH_W-1:0]   idx_q, idx_d;
    logic [WORD-1:0]      wdata_q, wdata_d;
    logic                 rej_q, rej_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [WORD-1:0]      rdata_q, rdata_d;

    logic                 misaligned;
    logic                 out_of_range;
    logic [DEPTH_W-1:0]   ram_addr;
    logic                 ram_we_lo, ram_we_hi;
    logic [WORD-1:0]      ram_wdata, ram_rdata;
    logic [7:0]           lane_byte;
    logic [7:0]           ext_byte;

    assign misaligned   = !byte_i && addr_i[0];
    assign out_of_range = (addr_i >> (DEPTH_W + 1)) != '0;

    // Read address follows addr_i in IDLE so data is ready when ACCESS is entered
    // directly (WAIT_STATES=0); otherwise the latched index is used.
    assign ram_addr  = (state_q == IDLE) ? addr_i[DEPTH_W:1] : idx_q;
    assign ram_we_lo = (state_q == ACCESS) && !rej_q && we_q && (!byte_q || lane_q == LANE_LO);
    assign ram_we_hi = (state_q == ACCESS) && !rej_q && we_q && (!byte_q || lane_q == LANE_HI);
    assign ram_wdata = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;

    assign lane_byte = (lane_q == LANE_HI) ? ram_rdata[15:8] : ram_rdata[7:0];
`ifdef MEM_BYTE_SIGN_EXTEND_EN
    assign ext_byte  = {8{lane_byte[7]}};
`else
    assign ext_byte  = '0;
`endif

    memory_byte_lane_ram #(
        .DEPTH_W (DEPTH_W)
    ) u_ram (
        .clk_i   (clk_i),
        .addr_i  (ram_addr),
        .we_lo_i (ram_we_lo),
        .we_hi_i (ram_we_hi),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        byte_d  = byte_q;
        lane_d  = lane_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rej_d   = rej_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    byte_d  = byte_i;
                    lane_d  = addr_i[0];
                    idx_d   = addr_i[DEPTH_W:1];
                    wdata_d = wdata_i;
                    rej_d   = misaligned || out_of_range;
                    // Rejected requests pass through ACCESS with storage gated off,
                    // giving the error ack its one-cycle decision latency.
                    if (misaligned || out_of_range || WAIT_STATES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ACCESS: begin
                state_d = RESP;
                ack_d   = 1'b1;
                err_d   = rej_q;
                if (!rej_q && !we_q) rdata_d = byte_q ? {ext_byte, lane_byte} : ram_rdata;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            lane_q  <= LANE_LO;
            idx_q   <= '0;
            wdata_q <= '0;
            rej_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            lane_q  <= lane_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rej_q   <= rej_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_memory_bus_responder.sv
// Directed bench for memory_bus_responder (WAIT_STATES=1, DEPTH_W=10).
module tb_memory_bus_responder;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic        byte_en;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic        busy;

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned n_total = 0;

    memory_bus_responder #(
        .WORD        (16),
        .ADDR_W      (16),
        .DEPTH_W     (10),
        .WAIT_STATES (1)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .req_i   (req),
        .we_i    (we),
        .byte_i  (byte_en),
        .addr_i  (addr),
        .wdata_i (wdata),
        .ack_o   (ack),
        .err_o   (err),
        .rdata_o (rdata),
        .busy_o  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; ack latency counted in edges after the accept edge.
    task automatic txn(input string tag, input logic w, input logic b, input logic [15:0] a,
                       input logic [15:0] d, input int exp_lat, input logic exp_err,
                       input logic [15:0] exp_rd);
        int lat;
        @(negedge clk);
        req = 1'b1; we = w; byte_en = b; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = 1'b0; byte_en = 1'b0; addr = 16'h0; wdata = 16'h0;
        check({tag, "_busy"}, 16'(busy), 16'h1);
        lat = 0;
        while (!ack && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
        check({tag, "_err"}, 16'(err), 16'(exp_err));
        check({tag, "_rdata"}, rdata, exp_rd);
    endtask

    initial begin
        logic [15:0] byte_a5_exp;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; byte_en = 1'b0; addr = '0; wdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ack", 16'(ack), 16'h0);
        check("rst_err", 16'(err), 16'h0);
        check("rst_rdata", rdata, 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        rst_n = 1'b1;

        txn("wr_beef",  1'b1, 1'b0, 16'h0010, 16'hBEEF, 2, 1'b0, 16'h0000);
        txn("rd_beef",  1'b0, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'hBEEF);
        txn("wrb_5a",   1'b1, 1'b1, 16'h0011, 16'h335A, 2, 1'b0, 16'h0000);
        txn("rd_5aef",  1'b0, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'h5AEF);
        txn("rdb_hi",   1'b0, 1'b1, 16'h0011, 16'h0000, 2, 1'b0, 16'h005A);
        txn("rdb_lo",   1'b0, 1'b1, 16'h0010, 16'h0000, 2, 1'b0, 16'h00EF);
        txn("wrb_a5",   1'b1, 1'b1, 16'h0011, 16'h00A5, 2, 1'b0, 16'h0000);
`ifdef MEM_BYTE_SIGN_EXTEND_EN
        byte_a5_exp = 16'hFFA5;
`else
        byte_a5_exp = 16'h00A5;
`endif
        txn("rdb_a5",   1'b0, 1'b1, 16'h0011, 16'h0000, 2, 1'b0, byte_a5_exp);
        txn("rd_a5ef",  1'b0, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'hA5EF);

        txn("wr_0000",  1'b1, 1'b0, 16'h0000, 16'h1357, 2, 1'b0, 16'h0000);
        txn("rd_odd",   1'b0, 1'b0, 16'h0003, 16'h0000, 1, 1'b1, 16'h0000);
        txn("wr_oor",   1'b1, 1'b0, 16'h0800, 16'hFFFF, 1, 1'b1, 16'h0000);
        txn("wrb_oor",  1'b1, 1'b1, 16'h0801, 16'h00CC, 1, 1'b1, 16'h0000);
        txn("wr_odd",   1'b1, 1'b0, 16'h0001, 16'hDEAD, 1, 1'b1, 16'h0000);
        txn("rd_0000",  1'b0, 1'b0, 16'h0000, 16'h0000, 2, 1'b0, 16'h1357);
        txn("wr_top",   1'b1, 1'b0, 16'h07FE, 16'hC0DE, 2, 1'b0, 16'h0000);
        txn("rd_top",   1'b0, 1'b0, 16'h07FE, 16'h0000, 2, 1'b0, 16'hC0DE);
        txn("rdb_top",  1'b0, 1'b1, 16'h07FF, 16'h0000, 2, 1'b0, 16'h00C0);

        // Request held high: accept every 4th cycle, one ack per accept.
        @(negedge clk);
        req = 1'b1; we = 1'b0; byte_en = 1'b0; addr = 16'h0010;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold_busy%0d", i), 16'(busy), 16'((i % 4) != 0));
            check($sformatf("hold_ack%0d", i), 16'(ack), 16'((i % 4) == 3));
            if ((i % 4) == 3) check($sformatf("hold_rd%0d", i), rdata, 16'hA5EF);
        end
        req = 1'b0; addr = 16'h0;
        repeat (3) @(negedge clk);
        check("hold_idle", 16'(busy), 16'h0);

        // Reset during WAIT abandons the write.
        txn("wr_old",   1'b1, 1'b0, 16'h0020, 16'hAAAA, 2, 1'b0, 16'h0000);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0;
        check("rstw_busy", 16'(busy), 16'h1);
        rst_n = 1'b0;
        #1;
        check("rstw_busy_async", 16'(busy), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rstw_noack%0d", i), 16'(ack), 16'h0);
        end
        txn("rd_old",   1'b0, 1'b0, 16'h0020, 16'h0000, 2, 1'b0, 16'hAAAA);

        // Reset while ack is high clears outputs without a clock edge.
        @(negedge clk);
        req = 1'b1; addr = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; addr = 16'h0;
        repeat (2) @(negedge clk);
        check("rstr_ack_pre", 16'(ack), 16'h1);
        check("rstr_rd_pre", rdata, 16'hA5EF);
        #1 rst_n = 1'b0;
        #1;
        check("rstr_ack", 16'(ack), 16'h0);
        check("rstr_err", 16'(err), 16'h0);
        check("rstr_rdata", rdata, 16'h0);
        check("rstr_busy", 16'(busy), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        txn("rd_after", 1'b0, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'hA5EF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
